// File: rtl/vitro_pkg.sv
// Shared types and helpers for the divider result capture path.
package vitro_pkg;

  localparam int DATA_SIZE_DEF = 10;
  localparam int RESULT_W      = 2 * DATA_SIZE_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FULL    = 2'd2
  } state_t;

  function automatic int depth(input int addr_size);
    return 1 << addr_size;
  endfunction

endpackage

// File: rtl/result_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-first).
module result_ram
  import vitro_pkg::*;
#(
  parameter int DW = RESULT_W,
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // Array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the output register is reset, matching BRAM output-register resets.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/result_writer.sv
// Captures one divider result per rising edge of i_valid into result_ram;
// provides a 1-cycle-latency read-back port for dump/debug.
//   state   | meaning
//   IDLE    | first cycle after reset/clear; writes still honoured
//   CAPTURE | storing results on each valid edge
//   FULL    | depth reached with WRAP=0; further results dropped
module result_writer
  import vitro_pkg::*;
#(
  parameter int DATA_SIZE = 10,
  parameter int ADDR_SIZE = 8,
  parameter bit WRAP      = 1'b0
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [2*DATA_SIZE-1:0] i_result,
  input  logic                   i_valid,
  input  logic                   i_clear,
  input  logic                   i_rd_en,
  input  logic [ADDR_SIZE-1:0]   i_rd_addr,
  output logic [2*DATA_SIZE-1:0] o_rd_data,
  output logic                   o_rd_valid,
  output logic [ADDR_SIZE:0]     o_count,
  output logic                   o_full,
  output logic                   o_overflow
);

  localparam int                 W       = 2 * DATA_SIZE;
  localparam int                 DEPTH   = depth(ADDR_SIZE);
  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(DEPTH);

  state_t                 state_q, state_d;
  logic                   valid_d_q;
  logic                   wr_evt;
  logic [ADDR_SIZE-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE:0]     count_q, count_d, count_inc;
  logic                   full_q, full_d;
  logic                   ovf_q, ovf_d;
  logic                   rd_valid_q;
  logic                   ram_we;

  assign wr_evt    = i_valid & ~valid_d_q;
  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    full_d   = full_q;
    ovf_d    = ovf_q;
    ram_we   = 1'b0;
    if (i_clear) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      count_d  = '0;
      full_d   = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, CAPTURE: begin
          state_d = CAPTURE;
          if (wr_evt) begin
            if (count_q == DEPTH_C) begin
              // Saturated: only reachable with WRAP=1, overwrite oldest.
              ovf_d = 1'b1;
              if (WRAP) begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
              end
            end else begin
              ram_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + 1'b1;
              count_d  = count_inc;
              if (count_inc == DEPTH_C) begin
                full_d = 1'b1;
                if (!WRAP) state_d = FULL;
              end
            end
          end
        end
        FULL: begin
          if (wr_evt) ovf_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      valid_d_q  <= 1'b0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_d_q  <= i_valid;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= i_rd_en;
    end
  end

  result_ram #(
    .DW (W),
    .AW (ADDR_SIZE)
  ) u_ram (
    .clk_i   (i_clock),
    .rst_i   (i_reset),
    .we_i    (ram_we & ~i_reset),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_result),
    .re_i    (i_rd_en),
    .raddr_i (i_rd_addr),
    .rdata_o (o_rd_data)
  );

  assign o_rd_valid = rd_valid_q;
  assign o_count    = count_q;
  assign o_full     = full_q;
  assign o_overflow = ovf_q;

endmodule
